// File: rtl/handwash_range_scheduler.sv
// Shares one ranging front-end between the left and right handwash channels
// and pushes gain configuration to the sensor after reset or on host request.
module handwash_range_scheduler #(
   parameter int unsigned PERIOD       = 1000,
   parameter int unsigned TIMEOUT      = 255,
   parameter logic [7:0]  DEFAULT_GAIN = 8'd128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        gainLoad,
   input  logic [7:0]  gainLeftIn,
   input  logic [7:0]  gainRightIn,
   output logic        rangeReq,
   output logic        rangeSel,
   input  logic        rangeAck,
   input  logic [15:0] rangeData,
   output logic        acceptLeftHandDistance,
   output logic [15:0] leftHandDistance,
   output logic        acceptRightHandDistance,
   output logic [15:0] rightHandDistance,
   output logic        acceptLeftHandGain,
   output logic [7:0]  leftHandGain,
   output logic        acceptRightHandGain,
   output logic [7:0]  rightHandGain,
   output logic        faultLeft,
   output logic        faultRight,
   output logic        busy
);

   localparam logic [15:0] PERIOD_RELOAD = 16'(PERIOD - 1);
   localparam logic [7:0]  TIMEOUT_CNT   = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      CFG,
      REQ,
      DELIVER
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [1:0]  phase;
   logic        ch;
   logic [7:0]  wait_cnt;
   logic [15:0] period_cnt;
   logic [15:0] distance;
   logic [7:0]  shadow_left;
   logic [7:0]  shadow_right;
   logic        pending_cfg;

   logic        round_start;
   logic        ack_taken;
   logic        timed_out;
   logic        cfg_exit;
   logic        deliver_exit;

   assign round_start  = (state == IDLE) && (state_next == REQ);
   assign ack_taken    = (state == REQ) && rangeAck;
   assign timed_out    = (state == REQ) && !rangeAck && (wait_cnt == TIMEOUT_CNT);
   assign cfg_exit     = (state == CFG) && (phase == 2'd2);
   assign deliver_exit = (state == DELIVER) && (phase == 2'd2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next              = state;
      rangeReq                = 1'b0;
      rangeSel                = 1'b0;
      acceptLeftHandDistance  = 1'b0;
      leftHandDistance        = '0;
      acceptRightHandDistance = 1'b0;
      rightHandDistance       = '0;
      acceptLeftHandGain      = 1'b0;
      leftHandGain            = '0;
      acceptRightHandGain     = 1'b0;
      rightHandGain           = '0;
      busy                    = (state != IDLE);

      case (state)
         IDLE: begin
            if (pending_cfg) begin
               state_next = CFG;
            end else if (enable && (period_cnt == '0)) begin
               state_next = REQ;
            end
         end
         CFG: begin
            leftHandGain        = shadow_left;
            rightHandGain       = shadow_right;
            acceptLeftHandGain  = (phase == 2'd1);
            acceptRightHandGain = (phase == 2'd1);
            if (phase == 2'd2) begin
               state_next = IDLE;
            end
         end
         REQ: begin
            rangeReq = 1'b1;
            rangeSel = ch;
            if (rangeAck || (wait_cnt == TIMEOUT_CNT)) begin
               state_next = DELIVER;
            end
         end
         DELIVER: begin
            if (ch) begin
               rightHandDistance       = distance;
               acceptRightHandDistance = (phase == 2'd1);
            end else begin
               leftHandDistance       = distance;
               acceptLeftHandDistance = (phase == 2'd1);
            end
            if (phase == 2'd2) begin
               state_next = ch ? IDLE : REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // phase paces the three-cycle CFG/DELIVER frames; it restarts on every state change
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase    <= '0;
         wait_cnt <= '0;
         ch       <= 1'b0;
      end else begin
         if ((state_next == state) && ((state == CFG) || (state == DELIVER))) begin
            phase <= phase + 2'd1;
         end else begin
            phase <= '0;
         end

         if ((state == REQ) && (state_next == REQ)) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end

         if (round_start) begin
            ch <= 1'b0;
         end else if (deliver_exit && !ch) begin
            ch <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt <= PERIOD_RELOAD;
      end else if (round_start || !enable) begin
         period_cnt <= PERIOD_RELOAD;
      end else if (period_cnt != '0) begin
         period_cnt <= period_cnt - 16'd1;
      end
   end

   // a timeout substitutes max distance so the datapath sees "no hand"
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         distance   <= '0;
         faultLeft  <= 1'b0;
         faultRight <= 1'b0;
      end else begin
         if (ack_taken) begin
            distance <= rangeData;
            if (ch) begin
               faultRight <= 1'b0;
            end else begin
               faultLeft <= 1'b0;
            end
         end else if (timed_out) begin
            distance <= '1;
            if (ch) begin
               faultRight <= 1'b1;
            end else begin
               faultLeft <= 1'b1;
            end
         end
      end
   end

   // a load coinciding with the CFG exit keeps the request pending
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_left  <= DEFAULT_GAIN;
         shadow_right <= DEFAULT_GAIN;
         pending_cfg  <= 1'b1;
      end else if (gainLoad) begin
         shadow_left  <= gainLeftIn;
         shadow_right <= gainRightIn;
         pending_cfg  <= 1'b1;
      end else if (cfg_exit) begin
         pending_cfg <= 1'b0;
      end
   end

endmodule
